mix_columns_seq: RTL
====================

# mix_columns_seq

Sequential AES MixColumns engine for the encryption round datapath; the forward-direction counterpart of the InvMixColumns row multipliers used on the decryption side. Accepts a 128-bit state over a valid/ready handshake, transforms one 32-bit column per clock through a single shared GF(2^8) column datapath, and presents the 128-bit result over a second valid/ready handshake. Sits between ShiftRows and AddRoundKey in the round pipeline.

## Interface
- No parameters; widths are fixed by AES.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream presents a state on data_in
- in_ready  output  1  engine can accept a state
- data_in  input  128  column c at [32c+31:32c]; byte r of a column at [32c+8r+7:32c+8r]
- out_valid  output  1  data_out holds a finished state
- out_ready  input  1  downstream accepts data_out
- data_out  output  128  transformed state, same byte layout as data_in
- inv_sel  input  1  present only with MIX_COLUMNS_INV_EN; 1 selects InvMixColumns

## Operation
- States: IDLE, BUSY, DONE. A 2-bit column counter col is used in BUSY.
- IDLE: in_ready=1. When in_valid=1, capture data_in into the working register, clear col to 0, go to BUSY.
- BUSY: each cycle, replace column col with MixColumns(column col) and increment col. After the col=3 update, go to DONE. in_ready=0.
- Forward column math, for r=0..3 with indices mod 4: b_r = 02·a_r ^ 03·a_{r+1} ^ a_{r+2} ^ a_{r+3}.
- 02·x = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00). 03·x = 02·x ^ x. All products are 8 bits.
- DONE: out_valid=1 and data_out = working register. When out_ready=1, return to IDLE. in_ready stays 0 in DONE; there is no bypass.
- data_out is the working register directly. It stays stable from DONE entry until the out_valid&&out_ready handshake, and keeps its value afterwards until the next block starts updating it.
- in_valid while not in IDLE is ignored. Upstream must hold data_in until in_ready.

## Timing
- Reset (asynchronous assertion, synchronous release): state=IDLE, col=0, in_ready=1, out_valid=0, data_out=128'h0. With the macro, the latched mode is also cleared to 0 (forward).
- Accept at edge N. Columns 0..3 are written at edges N+1..N+4. out_valid=1 after edge N+4.
- Earliest output handshake is at edge N+5; earliest next accept is at edge N+6. Minimum period is 6 cycles per state.
- Reset during BUSY or DONE discards the in-flight state with no partial output. The first accept after release behaves normally.
- out_ready held low keeps DONE and data_out unchanged indefinitely.

## Configuration
- MIX_COLUMNS_INV_EN defined: inv_sel port exists and is sampled on the accept edge only. With the latched mode=1, each column uses b_r = 0e·a_r ^ 0b·a_{r+1} ^ 0d·a_{r+2} ^ 09·a_{r+3}, built from repeated xtime. Latency and handshake are identical to forward mode.
- Not defined: no inv_sel port and forward-only logic.

## Test plan
- Reset: assert rst_n=0 mid-BUSY -> outputs return immediately to in_ready=1, out_valid=0, data_out=0. Next block after release is correct.
- Known vector: data_in=128'hc6c6c6c6_01010101_5c220af2_455313db -> data_out=128'hc6c6c6c6_01010101_9d58dc9f_bca14d8e, with out_valid rising exactly 4 edges after accept.
- Second vector: all columns 32'hd5d4d4d4 -> every column 32'hd6d7d5d5. Then all columns 32'h4c31262d -> every column 32'hf8bd7e4d.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> data_out stable, in_ready=0, and in_valid pulses are ignored. Raising out_ready -> IDLE next edge, and in_ready=1.
- Back-to-back: in_valid and out_ready held at 1 -> accepts occur every 6 cycles, and every result matches the golden model.
- With MIX_COLUMNS_INV_EN: inv_sel=1 on the bcа14d8e/9d58dc9f result state -> the original 455313db/5c220af2 columns are recovered. Toggling inv_sel during BUSY has no effect.

Source files
------------

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential AES MixColumns engine.
// A 128-bit state is accepted over a valid/ready handshake. One 32-bit column
// is transformed per clock through a shared GF(2^8) column datapath. The
// finished state is then presented over a second valid/ready handshake.
// Optional macro MIX_COLUMNS_INV_EN adds the inv_sel port and InvMixColumns.
// inv_sel is latched on the accept edge.
module mix_columns_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
`ifdef MIX_COLUMNS_INV_EN
    ,
    input  logic         inv_sel
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state;
    logic [1:0]   col;
    logic [127:0] work;
    logic [31:0]  col_in;
    logic [31:0]  col_out;
    logic [6:0]   col_base;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // One output byte of forward MixColumns, operands already rotated to row r
    function automatic logic [7:0] fwd_byte(input logic [7:0] a0, a1, a2, a3);
        return xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    logic mode;

    // One output byte of InvMixColumns: 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3
    function automatic logic [7:0] inv_byte(input logic [7:0] a0, a1, a2, a3);
        logic [7:0] p0_2, p0_4, p0_8;
        logic [7:0] p1_2, p1_8;
        logic [7:0] p2_4, p2_8;
        logic [7:0] p3_8;
        p0_2 = xtime(a0);
        p0_4 = xtime(p0_2);
        p0_8 = xtime(p0_4);
        p1_2 = xtime(a1);
        p1_8 = xtime(xtime(p1_2));
        p2_4 = xtime(xtime(a2));
        p2_8 = xtime(p2_4);
        p3_8 = xtime(xtime(xtime(a3)));
        return (p0_8 ^ p0_4 ^ p0_2) ^ (p1_8 ^ p1_2 ^ a1) ^ (p2_8 ^ p2_4 ^ a2) ^ (p3_8 ^ a3);
    endfunction
`endif

    assign col_base  = {col, 5'b00000};
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign data_out  = work;

    // Shared column datapath: transform the column currently selected by col
    always_comb begin
        col_in  = work[col_base +: 32];
        col_out = {fwd_byte(col_in[31:24], col_in[7:0],   col_in[15:8],  col_in[23:16]),
                   fwd_byte(col_in[23:16], col_in[31:24], col_in[7:0],   col_in[15:8]),
                   fwd_byte(col_in[15:8],  col_in[23:16], col_in[31:24], col_in[7:0]),
                   fwd_byte(col_in[7:0],   col_in[15:8],  col_in[23:16], col_in[31:24])};
`ifdef MIX_COLUMNS_INV_EN
        if (mode) begin
            col_out = {inv_byte(col_in[31:24], col_in[7:0],   col_in[15:8],  col_in[23:16]),
                       inv_byte(col_in[23:16], col_in[31:24], col_in[7:0],   col_in[15:8]),
                       inv_byte(col_in[15:8],  col_in[23:16], col_in[31:24], col_in[7:0]),
                       inv_byte(col_in[7:0],   col_in[15:8],  col_in[23:16], col_in[31:24])};
        end
`endif
    end

    // Handshake FSM, column counter and working register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= 2'd0;
            work  <= '0;
`ifdef MIX_COLUMNS_INV_EN
            mode  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= data_in;
                        col   <= 2'd0;
                        state <= BUSY;
`ifdef MIX_COLUMNS_INV_EN
                        mode  <= inv_sel;
`endif
                    end
                end
                BUSY: begin
                    work[col_base +: 32] <= col_out;
                    col                  <= col + 2'd1;
                    if (col == 2'd3) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
